// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit in front of the data-memory port.
// Turns one core load/store (byte/half/word) into one word-aligned dmem
// transaction: strobes, lane-replicated write data, misalignment detection,
// lane extraction and sign/zero extension of read data, one-cycle done pulse.
// Optional macro LSU_TIMEOUT_EN adds a response watchdog (p_TIMEOUT_CYCLES).
module lsu_dmem_ctrl #(
    parameter int p_ADDR_BITS      = 32,
    parameter int p_DATA_BITS      = 32,
    parameter int p_STRB_BITS      = p_DATA_BITS/8,
    parameter int p_TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lsu_valid,
    output logic                   lsu_ready,
    input  logic                   lsu_cmd,
    input  logic [1:0]             lsu_size,
    input  logic                   lsu_unsigned,
    input  logic [p_ADDR_BITS-1:0] lsu_addr,
    input  logic [p_DATA_BITS-1:0] lsu_wdata,
    output logic                   lsu_done,
    output logic [p_DATA_BITS-1:0] lsu_rdata,
    output logic                   lsu_err_misalign,
    output logic                   lsu_err_bus,
    output logic [p_ADDR_BITS-1:0] dmem_addr,
    output logic                   dmem_cmd,
    output logic                   dmem_req,
    input  logic                   dmem_resp,
    input  logic                   dmem_r_rddv,
    input  logic [p_DATA_BITS-1:0] dmem_r_data,
    input  logic                   dmem_w_ack,
    output logic [p_STRB_BITS-1:0] dmem_w_strb,
    output logic [p_DATA_BITS-1:0] dmem_w_data
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                 state, state_nx;
    logic                   uns_q;
    logic [1:0]             size_q;
    logic [1:0]             off_q;
    logic                   misalign;
    logic                   complete;
    logic                   timeout;
    logic [p_STRB_BITS-1:0] strb_nx;
    logic [p_DATA_BITS-1:0] wdata_nx;
    logic [p_DATA_BITS-1:0] shifted;
    logic [p_DATA_BITS-1:0] ext_data;

    // Only the response matching the in-flight command completes it
    assign complete  = (state == REQ) && (dmem_cmd ? dmem_w_ack : dmem_r_rddv);
    assign lsu_ready = (state == IDLE);
    assign dmem_req  = (state == REQ);
    assign lsu_done  = (state == RESP);

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(p_TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(p_TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] tmo_cnt;

    // Watchdog counts REQ cycles without completion; held at zero elsewhere
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        tmo_cnt <= '0;
        else if (state != REQ)          tmo_cnt <= '0;
        else if (!complete)             tmo_cnt <= tmo_cnt + 1'b1;
    end

    // A completion on the last allowed cycle still counts as a normal one
    assign timeout = (state == REQ) && !complete && (tmo_cnt == TMO_LAST);
`else
    assign timeout = 1'b0;
`endif

    // Illegal size or an address not aligned to the access size
    always_comb begin
        misalign = 1'b0;
        case (lsu_size)
            2'd1:    misalign = lsu_addr[0];
            2'd2:    misalign = |lsu_addr[1:0];
            2'd3:    misalign = 1'b1;
            default: misalign = 1'b0;
        endcase
    end

    // Store strobes and lane-replicated write data for the incoming request
    always_comb begin
        strb_nx  = '0;
        wdata_nx = lsu_wdata;
        case (lsu_size)
            2'd0: begin
                strb_nx  = p_STRB_BITS'(1) << lsu_addr[1:0];
                wdata_nx = {4{lsu_wdata[7:0]}};
            end
            2'd1: begin
                strb_nx  = p_STRB_BITS'(3) << lsu_addr[1:0];
                wdata_nx = {2{lsu_wdata[15:0]}};
            end
            default: strb_nx = '1;
        endcase
    end

    // Lane extraction and extension of the returned read word
    always_comb begin
        shifted  = dmem_r_data >> {off_q, 3'b000};
        ext_data = dmem_r_data;
        case (size_q)
            2'd0: ext_data = uns_q ? {{(p_DATA_BITS-8){1'b0}}, shifted[7:0]}
                                   : {{(p_DATA_BITS-8){shifted[7]}}, shifted[7:0]};
            2'd1: ext_data = uns_q ? {{(p_DATA_BITS-16){1'b0}}, shifted[15:0]}
                                   : {{(p_DATA_BITS-16){shifted[15]}}, shifted[15:0]};
            default: ext_data = dmem_r_data;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state: misaligned requests skip the bus and go straight to RESP
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (lsu_valid) state_nx = misalign ? RESP : REQ;
            REQ:     if (complete || timeout) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request latching, completion capture and flag clearing after done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_addr        <= '0;
            dmem_cmd         <= 1'b0;
            dmem_w_strb      <= '0;
            dmem_w_data      <= '0;
            size_q           <= '0;
            uns_q            <= 1'b0;
            off_q            <= '0;
            lsu_rdata        <= '0;
            lsu_err_misalign <= 1'b0;
            lsu_err_bus      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (lsu_valid) begin
                    if (misalign) begin
                        lsu_err_misalign <= 1'b1;
                    end else begin
                        dmem_addr   <= {lsu_addr[p_ADDR_BITS-1:2], 2'b00};
                        dmem_cmd    <= lsu_cmd;
                        dmem_w_strb <= lsu_cmd ? strb_nx : '0;
                        dmem_w_data <= lsu_cmd ? wdata_nx : '0;
                        size_q      <= lsu_size;
                        uns_q       <= lsu_unsigned;
                        off_q       <= lsu_addr[1:0];
                    end
                end
                REQ: begin
                    if (complete) begin
                        lsu_err_bus <= dmem_resp;
                        lsu_rdata   <= (dmem_cmd || dmem_resp) ? '0 : ext_data;
                    end else if (timeout) begin
                        lsu_err_bus <= 1'b1;
                        lsu_rdata   <= '0;
                    end
                end
                default: begin
                    lsu_rdata        <= '0;
                    lsu_err_misalign <= 1'b0;
                    lsu_err_bus      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Randomized self-checking bench for lsu_dmem_ctrl against a behavioural model.
// Honours LSU_TIMEOUT_EN when defined (adds the watchdog scenario).
module tb_lsu_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_valid = 1'b0, lsu_cmd = 1'b0, lsu_unsigned = 1'b0;
    logic [1:0]  lsu_size = '0;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0;
    logic        lsu_ready, lsu_done, lsu_err_misalign, lsu_err_bus;
    logic [31:0] lsu_rdata, dmem_addr, dmem_w_data;
    logic        dmem_cmd, dmem_req;
    logic        dmem_resp = 1'b0, dmem_r_rddv = 1'b0, dmem_w_ack = 1'b0;
    logic [31:0] dmem_r_data = '0;
    logic [3:0]  dmem_w_strb;

    int errs = 0;
    int checks = 0;

    lsu_dmem_ctrl dut (
        .clk(clk), .rst(rst),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_cmd(lsu_cmd),
        .lsu_size(lsu_size), .lsu_unsigned(lsu_unsigned), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
        .lsu_err_misalign(lsu_err_misalign), .lsu_err_bus(lsu_err_bus),
        .dmem_addr(dmem_addr), .dmem_cmd(dmem_cmd), .dmem_req(dmem_req),
        .dmem_resp(dmem_resp), .dmem_r_rddv(dmem_r_rddv), .dmem_r_data(dmem_r_data),
        .dmem_w_ack(dmem_w_ack), .dmem_w_strb(dmem_w_strb), .dmem_w_data(dmem_w_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---- reference model: plain arithmetic over the access rules ----
    function automatic bit m_misalign(input int size, input int addr);
        return (size == 3) || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
    endfunction

    function automatic logic [31:0] m_strb(input int size, input int off);
        int n;
        logic [31:0] s;
        s = 0;
        n = (size == 0) ? 1 : (size == 1) ? 2 : 4;
        for (int k = 0; k < n; k++) s = s + (32'd1 << (off + k));
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input int size, input logic [31:0] w);
        if (size == 0) return (w % 256) * 32'h01010101;
        if (size == 1) return (w % 65536) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] m_rdata(input int size, input bit uns, input int off,
                                            input logic [31:0] rd);
        logic [31:0] v;
        v = rd / (32'd1 << (8 * off));
        if (size == 0) begin
            v = v % 256;
            if (!uns && v >= 128) v = v + 32'hFFFFFF00;
        end else if (size == 1) begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF0000;
        end else v = rd;
        return v;
    endfunction

    // One full access: present request, service dmem after 'dly' wait cycles, check all
    task automatic access(input bit cmd, input int size, input bit uns, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd, input int dly,
                          input bit resp);
        logic [31:0] exp_rd;
        @(negedge clk);
        chk("ready_idle", {31'b0, lsu_ready}, 32'd1);
        lsu_valid = 1'b1; lsu_cmd = cmd; lsu_size = 2'(size); lsu_unsigned = uns;
        lsu_addr = addr; lsu_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        lsu_valid = 1'b0;
        lsu_wdata = $urandom; lsu_addr = $urandom;
        if (m_misalign(size, int'(addr % 4))) begin
            chk("mis_req", {31'b0, dmem_req}, 32'd0);
            chk("mis_done", {31'b0, lsu_done}, 32'd1);
            chk("mis_flag", {31'b0, lsu_err_misalign}, 32'd1);
            chk("mis_bus", {31'b0, lsu_err_bus}, 32'd0);
            chk("mis_rdata", lsu_rdata, 32'd0);
        end else begin
            for (int i = 0; i <= dly; i++) begin
                chk("req", {31'b0, dmem_req}, 32'd1);
                chk("ready_busy", {31'b0, lsu_ready}, 32'd0);
                chk("done_early", {31'b0, lsu_done}, 32'd0);
                chk("addr", dmem_addr, addr & 32'hFFFFFFFC);
                chk("cmd", {31'b0, dmem_cmd}, {31'b0, cmd});
                chk("strb", {28'b0, dmem_w_strb}, cmd ? m_strb(size, int'(addr % 4)) : 32'd0);
                if (cmd) chk("wdata", dmem_w_data, m_wdata(size, wd));
                dmem_r_data = $urandom;
                if (i == dly) begin
                    dmem_r_data = rd; dmem_resp = resp;
                    if (cmd) dmem_w_ack = 1'b1; else dmem_r_rddv = 1'b1;
                end else begin
                    // response of the wrong kind must be ignored
                    dmem_resp = 1'b1;
                    if (cmd) dmem_r_rddv = $urandom_range(0, 1);
                    else     dmem_w_ack  = $urandom_range(0, 1);
                end
                @(posedge clk);
                @(negedge clk);
                dmem_r_rddv = 1'b0; dmem_w_ack = 1'b0; dmem_resp = 1'b0;
            end
            exp_rd = (cmd || resp) ? 32'd0 : m_rdata(size, uns, int'(addr % 4), rd);
            chk("done", {31'b0, lsu_done}, 32'd1);
            chk("req_off", {31'b0, dmem_req}, 32'd0);
            chk("rdata", lsu_rdata, exp_rd);
            chk("err_bus", {31'b0, lsu_err_bus}, {31'b0, resp});
            chk("err_mis", {31'b0, lsu_err_misalign}, 32'd0);
        end
        @(negedge clk);
        chk("done_pulse", {31'b0, lsu_done}, 32'd0);
        chk("flags_clr", {30'b0, lsu_err_bus, lsu_err_misalign}, 32'd0);
    endtask

    initial begin
        #1;
        chk("rst_ready", {31'b0, lsu_ready}, 32'd1);
        chk("rst_outs", {28'b0, lsu_done, dmem_req, dmem_cmd, lsu_err_bus | lsu_err_misalign}, 32'd0);
        chk("rst_data", dmem_addr | dmem_w_data | lsu_rdata | {28'b0, dmem_w_strb}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // directed cases
        access(0, 2, 0, 32'h100, 32'h0, 32'h8899AABB, 0, 0);
        access(0, 0, 0, 32'h103, 32'h0, 32'h80FF0011, 0, 0);
        access(0, 0, 1, 32'h103, 32'h0, 32'h80FF0011, 1, 0);
        access(1, 1, 0, 32'h202, 32'h0000BEEF, 32'h0, 2, 0);
        access(0, 2, 0, 32'h101, 32'h0, 32'h0, 0, 0);
        access(1, 3, 0, 32'h0, 32'h12345678, 32'h0, 0, 0);
        access(0, 1, 0, 32'h302, 32'h0, 32'h8001_7FFF, 5, 1);
        access(0, 1, 0, 32'h302, 32'h0, 32'h8001_7FFF, 0, 0);

        // reset in the middle of a wait: req drops at once, no done
        @(negedge clk);
        lsu_valid = 1'b1; lsu_cmd = 1'b0; lsu_size = 2'd2; lsu_addr = 32'h400;
        @(negedge clk);
        lsu_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_req", {31'b0, dmem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_req_drop", {31'b0, dmem_req}, 32'd0);
        chk("rst_no_done", {31'b0, lsu_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, lsu_ready}, 32'd1);
        chk("post_rst_done", {31'b0, lsu_done}, 32'd0);

`ifdef LSU_TIMEOUT_EN
        begin
            int req_cycles;
            req_cycles = 0;
            @(negedge clk);
            lsu_valid = 1'b1; lsu_cmd = 1'b1; lsu_size = 2'd2; lsu_addr = 32'h500;
            @(negedge clk);
            lsu_valid = 1'b0;
            while (dmem_req && req_cycles < 40) begin
                req_cycles++;
                @(negedge clk);
            end
            chk("tmo_cycles", 32'(req_cycles), 32'd16);
            chk("tmo_done", {31'b0, lsu_done}, 32'd1);
            chk("tmo_bus", {31'b0, lsu_err_bus}, 32'd1);
            chk("tmo_rdata", lsu_rdata, 32'd0);
            @(negedge clk);
        end
`endif

        // randomized accesses
        for (int n = 0; n < 200; n++) begin
            int sz;
            logic [31:0] a;
            sz = $urandom_range(0, 3);
            a  = {$urandom_range(0, 4095), 2'b00} | 32'($urandom_range(0, 3));
            access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                   $urandom, $urandom_range(0, 4), $urandom_range(0, 7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
